// File: rtl/uart_pkg.sv
// Shared UART/ALU definitions.
// Used by uart_rx, uart_tx, the ALU and the frame assembler.
package uart_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_OP_DEFAULT   = 6;

  typedef enum logic [2:0] {
    S_GET_A   = 3'd0,
    S_GET_B   = 3'd1,
    S_GET_OP  = 3'd2,
    S_SEND    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer; saturates at its last count.
// Held at zero while disabled so every frame starts fresh.
module rx_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clear || !i_enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_expired = i_enable && (cnt == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Assembles A, B and opcode bytes for the ALU.
// Returns the ALU result to uart_tx as one byte.
module uart_alu_interface
  import uart_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEFAULT,
  parameter int NB_OP          = NB_OP_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err
);

  state_t state;
  logic   in_frame;
  logic   gap_en;
  logic   expired;

  assign in_frame = (state == S_GET_A) || gap_en;
  assign gap_en   = (state == S_GET_B) || (state == S_GET_OP);

  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_clear  (i_rx_done && in_frame),
    .i_enable (gap_en),
    .o_expired(expired)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_GET_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;
      unique case (state)
        S_GET_A: begin
          if (i_rx_done) begin
            o_data_a <= i_rx_data;
            state    <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (i_rx_done) begin
            o_data_b <= i_rx_data;
            state    <= S_GET_OP;
          end else if (expired) begin
            o_err <= 1'b1;
            state <= S_GET_A;
          end
        end
        S_GET_OP: begin
          if (i_rx_done) begin
            if (|i_rx_data[NB_DATA-1:NB_OP]) begin
              o_err <= 1'b1;
              state <= S_GET_A;
            end else begin
              o_op   <= i_rx_data[NB_OP-1:0];
              o_busy <= 1'b1;
              state  <= S_SEND;
            end
          end else if (expired) begin
            o_err <= 1'b1;
            state <= S_GET_A;
          end
        end
        S_SEND: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          o_err      <= i_rx_done;
          state      <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          o_err <= i_rx_done;
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= S_GET_A;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_GET_A;
        end
      endcase
    end
  end

endmodule
